// File: rtl/alu_dispatch_if.sv
// Request / ALU / response bundle between the control unit, the dispatcher and the ALU.
// The slave modport is the dispatcher's view; master is the surrounding environment's view.
interface alu_dispatch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_dat1;
  logic [31:0] req_dat2;
  logic [4:0]  req_instr;
  logic [4:0]  req_rd;

  logic [31:0] ALU_dat1;
  logic [31:0] ALU_dat2;
  logic [4:0]  Instruction_to_ALU;
  logic        dat_ready;
  logic [31:0] ALU_out;
  logic        ALU_overflow;
  logic        ALU_con_met;
  logic        ALU_zero;
  logic        ALU_ready;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_rd;
  logic [2:0]  rsp_flags;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_dat1, req_dat2, req_instr, req_rd,
    input  ALU_out, ALU_overflow, ALU_con_met, ALU_zero, ALU_ready,
    input  rsp_ready,
    output req_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU, dat_ready,
    output rsp_valid, rsp_result, rsp_rd, rsp_flags, rsp_err
  );

  modport master (
    output req_valid, req_dat1, req_dat2, req_instr, req_rd,
    output ALU_out, ALU_overflow, ALU_con_met, ALU_zero, ALU_ready,
    output rsp_ready,
    input  req_ready, ALU_dat1, ALU_dat2, Instruction_to_ALU, dat_ready,
    input  rsp_valid, rsp_result, rsp_rd, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_dispatch.sv
// Single-outstanding dispatcher: issues one CU request to a multi-cycle ALU, waits for its
// result (or a timeout) and holds the response until the downstream handshake.
module alu_dispatch #(
  parameter int TIMEOUT = 16
) (
  input  logic          soc_clk,
  input  logic          reset,
  alu_dispatch_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               legal;
  logic               capture;
  logic               expire;
  logic [CNT_W-1:0]   tmo_cnt;

  // A lingering ALU_ready from the previous operation must drop before reissue.
  assign bus.req_ready = (state == IDLE) && !bus.ALU_ready && !reset;
  assign bus.dat_ready = (state == WAIT);
  assign bus.rsp_valid = (state == RESP);

  always_ff @(posedge soc_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    legal      = (bus.req_instr[4] == 1'b0);
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          accept     = 1'b1;
          state_next = legal ? WAIT : RESP;
        end
      end
      WAIT: begin
        // A result arriving on the timeout edge still counts as a success.
        if (bus.ALU_ready) begin
          capture    = 1'b1;
          state_next = RESP;
        end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
          expire     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (reset) begin
      bus.ALU_dat1           <= '0;
      bus.ALU_dat2           <= '0;
      bus.Instruction_to_ALU <= '0;
      bus.rsp_result         <= '0;
      bus.rsp_rd             <= '0;
      bus.rsp_flags          <= '0;
      bus.rsp_err            <= 1'b0;
      tmo_cnt                <= '0;
    end else begin
      if (accept) begin
        bus.rsp_rd <= bus.req_rd;
        if (legal) begin
          bus.ALU_dat1           <= bus.req_dat1;
          bus.ALU_dat2           <= bus.req_dat2;
          bus.Instruction_to_ALU <= bus.req_instr;
          tmo_cnt                <= '0;
        end else begin
          bus.rsp_result <= '0;
          bus.rsp_flags  <= '0;
          bus.rsp_err    <= 1'b1;
        end
      end
      if (capture) begin
        bus.rsp_result <= bus.ALU_out;
        bus.rsp_flags  <= {bus.ALU_overflow, bus.ALU_con_met, bus.ALU_zero};
        bus.rsp_err    <= 1'b0;
      end
      if (expire) begin
        bus.rsp_result <= '0;
        bus.rsp_flags  <= '0;
        bus.rsp_err    <= 1'b1;
      end
      // Stops at TIMEOUT-1 because the expiring edge leaves WAIT.
      if ((state == WAIT) && !bus.ALU_ready && !expire) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a behavioural 4-cycle ALU and a response scoreboard.
// Expected responses are queued at issue time and matched by an independent monitor.
module tb_alu_dispatch;
  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic [2:0]  flags;
    logic        err;
    int          lat;
  } exp_t;

  logic soc_clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t sb[$];

  logic alu_rdy = 1'b0;
  logic alu_force = 1'b0;
  logic alu_hold = 1'b0;
  int   alu_cnt = 0;
  int   alu_lat = 3;

  alu_dispatch_if bus();

  alu_dispatch #(.TIMEOUT(16)) dut (
    .soc_clk (soc_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 soc_clk = ~soc_clk;
  always @(posedge soc_clk) cyc <= cyc + 1;

  // ALU raises ready on the 4th edge it sees dat_ready, drops it one edge after dat_ready falls.
  always @(posedge soc_clk) begin
    if (reset || !bus.dat_ready) begin
      alu_cnt <= 0;
      alu_rdy <= 1'b0;
    end else if (!alu_hold) begin
      if (alu_cnt == alu_lat) alu_rdy <= 1'b1;
      else                    alu_cnt <= alu_cnt + 1;
    end
  end
  assign bus.ALU_ready = alu_rdy | alu_force;

  always_comb begin
    bus.ALU_out      = '0;
    bus.ALU_overflow = 1'b0;
    bus.ALU_con_met  = 1'b0;
    bus.ALU_zero     = 1'b0;
    case (bus.Instruction_to_ALU)
      5'd0: bus.ALU_con_met = (bus.ALU_dat1 == bus.ALU_dat2);
      5'd1: bus.ALU_con_met = (bus.ALU_dat1 != bus.ALU_dat2);
      5'd6: begin
        bus.ALU_out      = bus.ALU_dat1 + bus.ALU_dat2;
        bus.ALU_overflow = (bus.ALU_dat1[31] == bus.ALU_dat2[31]) && (bus.ALU_out[31] != bus.ALU_dat1[31]);
        bus.ALU_zero     = (bus.ALU_out == 32'd0);
      end
      5'd7: begin
        bus.ALU_out      = bus.ALU_dat1 - bus.ALU_dat2;
        bus.ALU_overflow = (bus.ALU_dat1[31] != bus.ALU_dat2[31]) && (bus.ALU_out[31] != bus.ALU_dat1[31]);
        bus.ALU_zero     = (bus.ALU_out == 32'd0);
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] result, input logic [4:0] rd,
                            input logic [2:0] flags, input logic err, input int lat);
    exp_t e;
    e.result = result; e.rd = rd; e.flags = flags; e.err = err; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] d1, input logic [31:0] d2,
                       input logic [4:0] op, input logic [4:0] rd);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_dat1  = d1;
    bus.req_dat2  = d2;
    bus.req_instr = op;
    bus.req_rd    = rd;
    @(negedge soc_clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge soc_clk);
      n++;
    end
    check("accept_wait", 32'(n < 100), 32'd1);
    @(posedge soc_clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 100) begin
      @(posedge soc_clk); #1;
      n++;
    end
    check("drain_wait", 32'(n < 100), 32'd1);
    @(posedge soc_clk); #1;
  endtask

  // Monitor: latency is measured from the accepting edge to the edge raising rsp_valid.
  int   acc_cyc = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;
  exp_t got;
  initial begin
    forever begin
      @(negedge soc_clk);
      if (bus.req_valid && bus.req_ready) acc_cyc = cyc + 1;
      if (bus.rsp_valid && !prev_v) begin
        rise_cyc = cyc;
        check("dat_ready_at_rsp", 32'(bus.dat_ready), 32'd0);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got response rd=%0d, required none", bus.rsp_rd);
        end else begin
          got = sb.pop_front();
          check("rsp_result", bus.rsp_result, got.result);
          check("rsp_rd", 32'(bus.rsp_rd), 32'(got.rd));
          check("rsp_flags", 32'(bus.rsp_flags), 32'(got.flags));
          check("rsp_err", 32'(bus.rsp_err), 32'(got.err));
          if (got.lat >= 0) check("latency", 32'(rise_cyc - acc_cyc), 32'(got.lat));
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_dat1  = '0;
    bus.req_dat2  = '0;
    bus.req_instr = '0;
    bus.req_rd    = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge soc_clk);
    @(negedge soc_clk);
    check("rst_dat_ready", 32'(bus.dat_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_alu_dat1", bus.ALU_dat1, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge soc_clk); #1;
    reset = 1'b0;
    @(negedge soc_clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge soc_clk); #1;

    // ADD 5+7
    expect_rsp(32'd12, 5'd3, 3'b000, 1'b0, 5);
    issue(32'd5, 32'd7, 5'd6, 5'd3);
    check("add_dat_ready", 32'(bus.dat_ready), 32'd1);
    check("add_alu_dat1", bus.ALU_dat1, 32'd5);
    check("add_alu_instr", 32'(bus.Instruction_to_ALU), 32'd6);
    drain();

    expect_rsp(32'd0, 5'd4, 3'b010, 1'b0, 5);
    issue(32'd9, 32'd9, 5'd0, 5'd4);
    drain();
    expect_rsp(32'hFFFF_FFFE, 5'd7, 3'b000, 1'b0, 5);
    issue(32'd3, 32'd5, 5'd7, 5'd7);
    drain();
    expect_rsp(32'd0, 5'd8, 3'b001, 1'b0, 5);
    issue(32'd9, 32'd9, 5'd7, 5'd8);
    drain();
    expect_rsp(32'h8000_0000, 5'd10, 3'b100, 1'b0, 5);
    issue(32'h7FFF_FFFF, 32'd1, 5'd6, 5'd10);
    drain();

    // Illegal op: response on the accepting edge, ALU never engaged
    expect_rsp(32'd0, 5'd9, 3'b000, 1'b1, 0);
    issue(32'd1, 32'd2, 5'd16, 5'd9);
    check("illegal_dat_ready", 32'(bus.dat_ready), 32'd0);
    repeat (3) begin
      @(negedge soc_clk);
      check("illegal_dat_ready_hold", 32'(bus.dat_ready), 32'd0);
    end
    drain();

    // Timeout after 16 WAIT cycles
    alu_hold = 1'b1;
    expect_rsp(32'd0, 5'd11, 3'b000, 1'b1, 16);
    issue(32'd4, 32'd4, 5'd6, 5'd11);
    drain();
    alu_hold = 1'b0;

    // Result on the timeout edge wins; one edge earlier is a plain success
    alu_lat = 14;
    expect_rsp(32'd8, 5'd12, 3'b000, 1'b0, 16);
    issue(32'd4, 32'd4, 5'd6, 5'd12);
    drain();
    alu_lat = 13;
    expect_rsp(32'd6, 5'd15, 3'b000, 1'b0, 15);
    issue(32'd3, 32'd3, 5'd6, 5'd15);
    drain();
    alu_lat = 3;

    // Backpressure with a second request already waiting
    bus.rsp_ready = 1'b0;
    expect_rsp(32'd3, 5'd5, 3'b000, 1'b0, 5);
    issue(32'd1, 32'd2, 5'd6, 5'd5);
    expect_rsp(32'd30, 5'd6, 3'b000, 1'b0, 5);
    bus.req_valid = 1'b1;
    bus.req_dat1  = 32'd10;
    bus.req_dat2  = 32'd20;
    bus.req_instr = 5'd6;
    bus.req_rd    = 5'd6;
    begin
      int n = 0;
      while (!bus.rsp_valid && n < 50) begin
        @(negedge soc_clk);
        n++;
      end
      check("bp_rsp_wait", 32'(n < 50), 32'd1);
    end
    repeat (10) begin
      @(negedge soc_clk);
      check("bp_result", bus.rsp_result, 32'd3);
      check("bp_rd", 32'(bus.rsp_rd), 32'd5);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    @(posedge soc_clk); #1;
    bus.rsp_ready = 1'b1;
    issue(32'd10, 32'd20, 5'd6, 5'd6);
    drain();

    // ALU_ready seen in IDLE blocks acceptance but yields no response
    expect_rsp(32'd2, 5'd13, 3'b000, 1'b0, 5);
    alu_force     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_dat1  = 32'd1;
    bus.req_dat2  = 32'd1;
    bus.req_instr = 5'd6;
    bus.req_rd    = 5'd13;
    repeat (3) begin
      @(negedge soc_clk);
      check("alu_rdy_blocks", 32'(bus.req_ready), 32'd0);
    end
    @(posedge soc_clk); #1;
    alu_force = 1'b0;
    issue(32'd1, 32'd1, 5'd6, 5'd13);
    drain();

    // Reset two edges after acceptance abandons the operation
    issue(32'd2, 32'd3, 5'd6, 5'd14);
    @(posedge soc_clk); #1;
    reset = 1'b1;
    @(posedge soc_clk); #1;
    reset = 1'b0;
    check("rw_dat_ready", 32'(bus.dat_ready), 32'd0);
    check("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rw_alu_dat1", bus.ALU_dat1, 32'd0);
    alu_force = 1'b1;
    @(posedge soc_clk); #1;
    alu_force = 1'b0;
    repeat (6) begin
      @(negedge soc_clk);
      check("rw_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    @(posedge soc_clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles before ALU_ready is declared lost.
REQ-002 soc_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  upstream (CU) request present.
REQ-005 req_ready  out  1  dispatcher accepts a request this cycle.
REQ-006 req_dat1 / req_dat2  in  32 each  operand values.
REQ-007 req_instr  in  5  ALU op code (0-15 legal, 0-5 branch, 6-15 I/R).
REQ-008 req_rd  in  5  destination tag, returned unchanged.
REQ-009 ALU_dat1 / ALU_dat2  out  32 each  operands driven to ALU.
REQ-010 Instruction_to_ALU  out  5  op code driven to ALU.
REQ-011 dat_ready  out  1  operands valid; held high for the whole ALU operation.
REQ-012 ALU_out  in  32  ALU result.
REQ-013 ALU_overflow, ALU_con_met, ALU_zero  in  1 each  ALU flags.
REQ-014 ALU_ready  in  1  ALU result valid; stays high while dat_ready high; falls one edge after dat_ready falls.
REQ-015 rsp_valid  out  1  response present.
REQ-016 rsp_ready  in  1  downstream accepts response.
REQ-017 rsp_result  out  32  captured result.
REQ-018 rsp_rd  out  5  captured tag.
REQ-019 rsp_flags  out  3  {overflow, con_met, zero}.
REQ-020 rsp_err  out  1  illegal op or timeout.

Function
REQ-021 FSM states IDLE, WAIT, RESP; single outstanding operation; no request queue.
REQ-022 req_ready = (state==IDLE) && !ALU_ready && !reset; combinational.
REQ-023 IDLE, req_valid&&req_ready, req_instr<=15: latch dat1/dat2/instr/rd to ALU_* and tag register, dat_ready=1 next cycle, clear timeout counter, go WAIT.
REQ-024 IDLE, accepted req_instr>=16: no ALU issue (dat_ready stays 0), rsp_result=0, rsp_flags=0, rsp_err=1, go RESP.
REQ-025 ALU_dat1/ALU_dat2/Instruction_to_ALU hold stable from acceptance until the next acceptance.
REQ-026 WAIT, ALU_ready=1: capture ALU_out and flags into rsp_*, rsp_err=0, dat_ready=0, go RESP, all at the same edge.
REQ-027 WAIT, ALU_ready=0: increment timeout counter; when counter reaches TIMEOUT-1 at an edge: rsp_result=0, rsp_flags=0, rsp_err=1, dat_ready=0, go RESP.
REQ-028 ALU_ready and timeout at the same edge: ALU_ready wins, no error.
REQ-029 Nominal latency with the 4-cycle ALU: rsp_valid rises 5 edges after the accepting edge.
REQ-030 RESP: rsp_valid=1; rsp_result/rsp_rd/rsp_flags/rsp_err stable until rsp_valid&&rsp_ready; then go IDLE and rsp_valid=0 the next cycle.
REQ-031 A new request is not accepted in the handshake cycle (no bypass); minimum spacing is set by REQ-022, which guarantees dat_ready low for at least one edge before reissue.
REQ-032 ALU_ready seen in IDLE or RESP is ignored apart from blocking req_ready.
REQ-033 Timeout counter width = clog2(TIMEOUT)+1; counter never wraps.

Reset
REQ-034 On reset at an edge: state=IDLE; dat_ready, rsp_valid, rsp_err = 0; ALU_dat1, ALU_dat2, Instruction_to_ALU, rsp_result, rsp_rd, rsp_flags, counter = 0.
REQ-035 Reset in WAIT or RESP abandons the operation: no response is emitted; a late ALU_ready is ignored per REQ-032.
REQ-036 Reset has priority over every other event at the same edge.

Verification
REQ-037 ADD: dat1=5, dat2=7, instr=6, rd=3, rsp_ready=1 -> dat_ready high 1 edge after accept; rsp_valid 5 edges after accept; result=12, rd=3, flags=000, err=0.
REQ-038 BEQ: dat1=dat2=9, instr=0 -> rsp_result=0, rsp_flags=010, err=0.
REQ-039 Illegal: instr=16 -> dat_ready never rises; rsp_valid next edge with err=1, result=0.
REQ-040 Timeout: ALU model holds ALU_ready=0 -> rsp_valid after 16 WAIT cycles, err=1, dat_ready=0 at that same edge.
REQ-041 Backpressure: rsp_ready=0 for 10 cycles -> payload stable, req_ready=0; next request accepted only after the handshake and with ALU_ready=0.
REQ-042 Reset in WAIT, 2 cycles after accept -> next cycle dat_ready=0, rsp_valid=0; ALU_ready pulse afterwards produces no response.
